systolic_feeder_4x4: RTL

- Input staging stage directly upstream of the 4x4 systolic array.
- Buffers up to DEPTH feature vectors of 4 lanes each.
- Streams them onto the array's west-edge feature inputs (FDi0, FDi4, FDi8, FDi12) with diagonal skew: lane i is delayed i cycles.
- Zero-fills the skew gaps, then issues a done pulse and a result_ld pulse for the array.

---
 rtl/systolic_feeder_4x4.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder_4x4.sv
// -----------------------------------------------------------------------------
// systolic_feeder_4x4
//
// Input staging buffer for a 4x4 systolic array. It holds up to DEPTH
// four-lane feature vectors and streams them onto the array's west-edge
// feature inputs with a diagonal skew, so that lane i is delayed by i cycles.
// The gaps that the skew opens up are filled with zeros. After the last
// stream cycle the block pulses done and result_ld together.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   wr_en      buffer write strobe (honoured in IDLE only)
//   wr_addr    vector index to write
//   wr_data    one vector; lane0 in the LSBs, lane3 in the MSBs
//   start      begin streaming (sampled in IDLE only)
//   len        number of vectors to stream, legal range 1..DEPTH
//   busy       high while streaming
//   done       one-cycle pulse after the last stream cycle
//   err        one-cycle pulse when start is sampled with an illegal len
//   result_ld  one-cycle pulse to the array, coincident with done
//   FDi0..12   lane0..lane3 features to array rows 0..3
//   lane_vld   bit i high when lane i carries real data, not skew fill
// -----------------------------------------------------------------------------
module systolic_feeder_4x4 #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [4*DATA_WIDTH-1:0] wr_data,
    input  logic                    start,
    input  logic [ADDR_W:0]         len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    result_ld,
    output logic [DATA_WIDTH-1:0]   FDi0,
    output logic [DATA_WIDTH-1:0]   FDi4,
    output logic [DATA_WIDTH-1:0]   FDi8,
    output logic [DATA_WIDTH-1:0]   FDi12,
    output logic [3:0]              lane_vld
);

    localparam int TW = ADDR_W + 2;   // stream counter width, holds DEPTH+2
    localparam int LW = ADDR_W + 1;   // length width, holds DEPTH

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_n;
    logic [TW-1:0]           r_t;
    logic [TW-1:0]           w_t_n;
    logic [LW-1:0]           r_len;
    logic [LW-1:0]           w_len_n;

    logic [4*DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                    w_wr_acc;
    logic                    w_len_ok;
    logic                    w_err_n;

    logic [TW-1:0]           w_diff [4];
    logic [ADDR_W-1:0]       w_idx  [4];
    logic [4*DATA_WIDTH-1:0] w_vec  [4];
    logic [DATA_WIDTH-1:0]   w_lane [4];
    logic [3:0]              w_vld;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_result_ld;
    logic [3:0]              r_lane_vld;
    logic [DATA_WIDTH-1:0]   r_fd [4];

    assign w_wr_acc = wr_en && (r_state == S_IDLE);
    assign w_len_ok = (len != '0) && (len <= LW'(DEPTH));

    // Buffer: no reset, contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_n;
            r_t     <= w_t_n;
            r_len   <= w_len_n;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        w_t_n     = r_t;
        w_len_n   = r_len;
        w_err_n   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_n = S_STREAM;
                        w_t_n     = '0;
                        w_len_n   = len;
                    end else begin
                        w_err_n   = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (r_t == TW'(r_len) + TW'(2)) begin
                    w_state_n = S_DONE;
                    w_t_n     = '0;
                end else begin
                    w_t_n     = r_t + TW'(1);
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
                w_t_n     = '0;
            end
        endcase
    end

    // Output logic: outputs are registered, so the values for cycle t are
    // computed from the next state/counter. A write accepted on the same
    // edge as start is forwarded so the first stream cycle sees it.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_diff[i] = w_t_n - TW'(i);
            w_idx[i]  = w_diff[i][ADDR_W-1:0];
            w_vld[i]  = (w_state_n == S_STREAM) && (w_t_n >= TW'(i)) &&
                        (w_diff[i] < TW'(w_len_n));
            w_vec[i]  = (w_wr_acc && (wr_addr == w_idx[i])) ? wr_data
                                                            : r_mem[w_idx[i]];
            w_lane[i] = w_vld[i] ? w_vec[i][i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_result_ld <= 1'b0;
            r_lane_vld  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_fd[i] <= '0;
            end
        end else begin
            r_busy      <= (w_state_n == S_STREAM);
            r_done      <= (w_state_n == S_DONE);
            r_err       <= w_err_n;
            r_result_ld <= (w_state_n == S_DONE);
            r_lane_vld  <= w_vld;
            for (int unsigned i = 0; i < 4; i++) begin
                r_fd[i] <= w_lane[i];
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign result_ld = r_result_ld;
    assign lane_vld  = r_lane_vld;
    assign FDi0      = r_fd[0];
    assign FDi4      = r_fd[1];
    assign FDi8      = r_fd[2];
    assign FDi12     = r_fd[3];

endmodule
